seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Time-multiplexing scan controller for the 8-digit common-anode 7-segment display on the board. It takes the 32-bit counter value as eight hex nibbles, snapshots it once per frame, and drives one digit at a time, inserting an all-off guard interval between digits to suppress ghosting. It sits between the 32-bit up/down counter and the AN/CA..CG/DP pins, and is the only block that owns those pins.

## Interface
- DIGIT_PERIOD, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be > GUARD_CYCLES
- GUARD_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be >= 1
- Clock  in  1  system clock (100 MHz)
- Clear  in  1  reset, asynchronous, active-high
- Enable  in  1  1 = scan display; 0 = display dark
- Value  in  32  hex value; nibble i is shown on digit i (AN0 = Value[3:0])
- Dp_mask  in  8  bit i = 1 lights DP on digit i
- AN  out  8  digit anodes, active-low
- Seg  out  7  segments, active-low, Seg[0]=CA ... Seg[6]=CG
- DP  out  1  decimal point, active-low
- Frame_done  out  1  one-cycle pulse at the last cycle of a full frame

## Operation
- All outputs are registered. Reset values: AN=8'hFF, Seg=7'h7F, DP=1, Frame_done=0; internal state IDLE, digit index 0, slot counter 0, snapshot 0.
- States: IDLE (AN=FF, Seg=7F, DP=1), GUARD (AN=FF, Seg/DP already showing the current digit), DRIVE (AN[idx]=0, all other AN bits 1).
- IDLE -> GUARD(idx 0) on an edge where Enable=1; Value and Dp_mask are captured into the snapshot on that same edge.
- GUARD -> DRIVE after GUARD_CYCLES cycles. DRIVE -> GUARD(idx+1) after DIGIT_PERIOD-GUARD_CYCLES cycles.
- From DRIVE of idx 7: wraps to GUARD(idx 0) and takes a new snapshot on that edge; Frame_done=1 during the last DRIVE cycle of idx 7.
- Enable=0 on any edge: next state IDLE, idx and slot counter reset to 0, outputs go dark on that edge. A partial frame never asserts Frame_done.
- Value changes mid-frame are not displayed until the next snapshot, so there is no tearing within a frame.
- Decoding is standard hex, active-low. Examples: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, E=7'b0000110, F=7'b0001110.
- Clear asserted mid-frame returns every register to its reset value immediately. Operation resumes from IDLE after Clear is released.

## Timing
- Slot = DIGIT_PERIOD cycles; frame = 8*DIGIT_PERIOD cycles (8 ms at the default settings).
- Latency: Enable sampled high at edge k gives Seg/DP for digit 0 valid from edge k and AN0 low from edge k+GUARD_CYCLES.
- Seg/DP change only at the first GUARD cycle of a slot, never while an anode is low.
- Frame_done is high exactly 1 cycle per 8*DIGIT_PERIOD cycles while Enable stays high.

## Configuration
- LEADING_ZERO_BLANK_EN defined: digit i (i >= 1) has Seg=7'h7F when snapshot nibbles i..7 are all zero. Digit 0 is never blanked. DP still follows Dp_mask. The anode scan timing is unchanged.
- Not defined: all eight digits always show their hex value, including leading zeros.

## Structure
- The shared package/include holds NUM_DIGITS=8, the 16 segment code constants, SEG_OFF=7'h7F, AN_OFF=8'hFF, and the state encodings IDLE/GUARD/DRIVE.
- One sub-module: hex_to_7seg (4-bit in, 7-bit active-low out, combinational). Its output is registered in the controller.

## Test plan
(Use DIGIT_PERIOD=8 and GUARD_CYCLES=2 for simulation.)
- Reset: Clear=1 with Enable=1 -> AN=FF, Seg=7F, DP=1, Frame_done=0. Release Clear -> AN0 goes low 2 cycles after the first edge with Enable=1.
- Scan: Value=32'h89ABCDEF, Dp_mask=8'h01 -> AN0 low with Seg=7'b0001110 and DP=0; AN7 low with Seg=7'b0000000; each digit is low 6 of every 8 cycles; Frame_done pulses every 64 cycles.
- Snapshot: change Value from 32'h11111111 to 32'h22222222 during digit 3 -> digits 4..7 still show 1 (7'b1111001); the new value appears only after Frame_done.
- Enable drop: Enable=0 during DRIVE of digit 5 -> AN=FF on the next edge and no Frame_done. Re-enable -> the scan restarts at digit 0 with the GUARD interval.
- Blanking (macro defined): Value=32'h00000000 -> only digit 0 shows 7'b1000000 and the others show 7F. Value=32'h00000A00 -> digits 3..7 blank, digit 2 shows A, digits 1..0 show 0. Macro undefined -> all digits show their value.
- Clear mid-frame during DRIVE of digit 2 -> all outputs return to reset values on the same cycle; after release, the scan restarts from digit 0.

Source files
------------

// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared constants for the 8-digit seven-segment scan controller:
// active-low segment codes, blanking values and FSM state encodings.
package seven_segment_scan_controller_pkg;

  localparam int NUM_DIGITS = 8;

  // Segment order is {CG,CF,CE,CD,CC,CB,CA}; a 0 lights the segment.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/seven_segment_scan_controller_if.sv
// Bundle between the counter/display pins and the scan controller.
interface seven_segment_scan_controller_if;
  import seven_segment_scan_controller_pkg::*;

  // No valid/ready handshake: enable is a level. value/dp_mask are sampled
  // only on frame-start edges while enable is high; display outputs and
  // frame_done are free-running registered outputs; state is debug only.
  logic        enable;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  state_t      state;

  modport master (
    output enable, value, dp_mask,
    input  an, seg, dp, frame_done, state
  );

  modport slave (
    input  enable, value, dp_mask,
    output an, seg, dp, frame_done, state
  );
endinterface

// File: rtl/seven_segment_scan_controller_hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import seven_segment_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// 8-digit common-anode scan controller with per-slot guard interval and
// per-frame snapshot. Optional macro: LEADING_ZERO_BLANK_EN.
module seven_segment_scan_controller
  import seven_segment_scan_controller_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  seven_segment_scan_controller_if.slave bus
);

  localparam int CW           = $clog2(DIGIT_PERIOD);
  localparam int IW           = $clog2(NUM_DIGITS);
  localparam int DRIVE_CYCLES = DIGIT_PERIOD - GUARD_CYCLES;
  localparam logic [CW-1:0] GUARD_LAST    = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST    = CW'(DRIVE_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_PRELAST = CW'((DRIVE_CYCLES >= 2) ? DRIVE_CYCLES - 2 : 0);
  localparam logic [IW-1:0] LAST_IDX      = IW'(NUM_DIGITS - 1);
  localparam bit            SHORT_DRIVE   = (DRIVE_CYCLES == 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [31:0]   snap;
  logic [7:0]    snap_dp;
  logic [7:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic          fd_r;

  logic          guard_done, drive_done, wrap, load, blank, fd_next;
  logic [IW-1:0] next_idx;
  logic [31:0]   src_val;
  logic [7:0]    src_dp;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg, next_seg;

  assign guard_done = (state == GUARD) && (cnt == GUARD_LAST);
  assign drive_done = (state == DRIVE) && (cnt == DRIVE_LAST);
  assign wrap       = drive_done && (idx == LAST_IDX);
  // Frame start (from IDLE or wrap) reads live inputs so digit 0 is correct
  // on the very edge the snapshot is taken.
  assign load       = (state == IDLE) || wrap;
  assign next_idx   = load ? '0 : idx + 1'b1;
  assign src_val    = load ? bus.value : snap;
  assign src_dp     = load ? bus.dp_mask : snap_dp;
  assign nibble     = src_val[{next_idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [31:0] upper;
  assign upper = src_val >> {next_idx, 2'b00};
  assign blank = (next_idx != '0) && (upper == 32'd0);
`else
  assign blank = 1'b0;
`endif

  hex_to_7seg u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  assign next_seg = blank ? SEG_OFF : dec_seg;
  assign fd_next  = (idx == LAST_IDX) &&
                    ((!SHORT_DRIVE && state == DRIVE && cnt == DRIVE_PRELAST) ||
                     (SHORT_DRIVE && guard_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      snap    <= '0;
      snap_dp <= '0;
      an_r    <= AN_OFF;
      seg_r   <= SEG_OFF;
      dp_r    <= 1'b1;
      fd_r    <= 1'b0;
    end else if (!bus.enable) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
      dp_r  <= 1'b1;
      fd_r  <= 1'b0;
    end else begin
      fd_r <= fd_next;
      case (state)
        IDLE: begin
          state   <= GUARD;
          idx     <= '0;
          cnt     <= '0;
          snap    <= bus.value;
          snap_dp <= bus.dp_mask;
          an_r    <= AN_OFF;
          seg_r   <= next_seg;
          dp_r    <= ~src_dp[next_idx];
        end
        GUARD: begin
          if (guard_done) begin
            state <= DRIVE;
            cnt   <= '0;
            an_r  <= ~(8'd1 << idx);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (drive_done) begin
            state <= GUARD;
            cnt   <= '0;
            idx   <= next_idx;
            an_r  <= AN_OFF;
            seg_r <= next_seg;
            dp_r  <= ~src_dp[next_idx];
            if (wrap) begin
              snap    <= bus.value;
              snap_dp <= bus.dp_mask;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.frame_done = fd_r;
  assign bus.state      = state;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: time-based reference model feeding
// an expected queue, negedge monitor, directed spot checks and random values.
module tb_seven_segment_scan_controller;
  import seven_segment_scan_controller_pkg::*;

  localparam int P     = 8;
  localparam int G     = 2;
  localparam int FRAME = 8 * P;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_ZERO = 7'h7F;
`else
  localparam logic [6:0] LEAD_ZERO = 7'b1000000;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_scan_controller_if bus ();

  seven_segment_scan_controller #(
    .DIGIT_PERIOD (P),
    .GUARD_CYCLES (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // reference model: display position derived from time since enable
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [31:0] m_snap = '0;
  logic [7:0]  m_dp = '0;
  int          m_slot, m_off;
  logic [7:0]  m_an;

  function automatic logic [6:0] exp_seg(input logic [31:0] s, input int d);
    logic [3:0] nib;
    nib = s[d*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (s >> (4 * d)) == 32'd0) return 7'h7F;
`endif
    return SEG_TAB[nib];
  endfunction

  always @(posedge clk) begin
    if (rst || !bus.enable) begin
      m_run = 1'b0;
      m_t   = 0;
      if (rst) begin
        m_snap = '0;
        m_dp   = '0;
      end
      exp_q.push_back({8'hFF, 7'h7F, 1'b1, 1'b0});
    end else begin
      if (!m_run) begin
        m_run  = 1'b1;
        m_t    = 0;
        m_snap = bus.value;
        m_dp   = bus.dp_mask;
      end else begin
        m_t++;
        if (m_t == FRAME) begin
          m_t    = 0;
          m_snap = bus.value;
          m_dp   = bus.dp_mask;
        end
      end
      m_slot = m_t / P;
      m_off  = m_t % P;
      m_an   = (m_off < G) ? 8'hFF : ~(8'h01 << m_slot);
      exp_q.push_back({m_an, exp_seg(m_snap, m_slot), ~m_dp[m_slot], 1'(m_t == FRAME - 1)});
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [16:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_an", bus.an, e[16:9]);
      check("sb_seg", bus.seg, e[8:2]);
      check("sb_dp", bus.dp, e[1]);
      check("sb_frame_done", bus.frame_done, e[0]);
    end
  end

  // driver tasks: all inputs change at negedge+2
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_an(input logic [7:0] target, input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (bus.an === target) break;
    end
    if (k == 200) check(tag, bus.an, target);
  endtask

  task automatic wait_fd(input string tag);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (bus.frame_done === 1'b1) break;
    end
    if (k == 200) check(tag, bus.frame_done, 1'b1);
  endtask

  task automatic measure_an0(input string tag);
    int n;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      #2;
      if (bus.an === 8'hFE) break;
    end
    check(tag, n, G + 1);
  endtask

  task automatic count_window(input int cycles, output int an0_low, output int fd_cnt);
    an0_low = 0;
    fd_cnt  = 0;
    repeat (cycles) begin
      @(negedge clk);
      #2;
      if (bus.an === 8'hFE) an0_low++;
      if (bus.frame_done === 1'b1) fd_cnt++;
    end
  endtask

  initial begin
    int low0, fdc;
    bus.enable  = 1'b1;
    bus.value   = 32'h89ABCDEF;
    bus.dp_mask = 8'h01;
    rst         = 1'b1;

    // reset with enable high
    step(3);
    check("rst_an", bus.an, 8'hFF);
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_dp", bus.dp, 1'b1);
    check("rst_frame_done", bus.frame_done, 1'b0);
    rst = 1'b0;
    measure_an0("rst_release_latency");

    // scan of 89ABCDEF
    check("d0_seg", bus.seg, 7'b0001110);
    check("d0_dp", bus.dp, 1'b0);
    wait_an(8'h7F, "wait_an7");
    check("d7_seg", bus.seg, 7'b0000000);
    check("d7_dp", bus.dp, 1'b1);
    count_window(2 * FRAME, low0, fdc);
    check("an0_low_per_2frames", low0, 2 * (P - G));
    check("fd_per_2frames", fdc, 2);

    // snapshot: mid-frame change must not tear
    bus.value = 32'h11111111;
    wait_fd("wait_fd_snap1");
    wait_an(8'hF7, "wait_an3");
    bus.value = 32'h22222222;
    wait_an(8'hEF, "wait_an4");
    check("snap_d4_seg", bus.seg, 7'b1111001);
    wait_an(8'h7F, "wait_an7_snap");
    check("snap_d7_seg", bus.seg, 7'b1111001);
    wait_fd("wait_fd_snap2");
    wait_an(8'hFE, "wait_an0_snap");
    check("new_d0_seg", bus.seg, 7'b0100100);

    // enable drop during digit 5
    wait_an(8'hDF, "wait_an5");
    bus.enable = 1'b0;
    step(1);
    check("drop_an", bus.an, 8'hFF);
    check("drop_seg", bus.seg, 7'h7F);
    count_window(80, low0, fdc);
    check("drop_no_fd", fdc, 0);
    bus.enable = 1'b1;
    measure_an0("reenable_latency");
    check("reenable_d0_seg", bus.seg, 7'b0100100);

    // clear mid-frame during digit 2
    wait_an(8'hFB, "wait_an2");
    rst = 1'b1;
    #1;
    check("clr_an", bus.an, 8'hFF);
    check("clr_seg", bus.seg, 7'h7F);
    check("clr_dp", bus.dp, 1'b1);
    check("clr_frame_done", bus.frame_done, 1'b0);
    check("clr_state", bus.state, IDLE);
    step(2);
    rst = 1'b0;
    measure_an0("clr_restart_latency");

    // leading zeros
    bus.value   = 32'h00000000;
    bus.dp_mask = 8'h00;
    wait_fd("wait_fd_zero");
    wait_an(8'hFE, "wait_an0_zero");
    check("zero_d0_seg", bus.seg, 7'b1000000);
    wait_an(8'hFD, "wait_an1_zero");
    check("zero_d1_seg", bus.seg, LEAD_ZERO);
    bus.value = 32'h00000A00;
    wait_fd("wait_fd_a00");
    wait_an(8'hFD, "wait_an1_a00");
    check("a00_d1_seg", bus.seg, 7'b1000000);
    wait_an(8'hFB, "wait_an2_a00");
    check("a00_d2_seg", bus.seg, 7'b0001000);
    wait_an(8'hF7, "wait_an3_a00");
    check("a00_d3_seg", bus.seg, LEAD_ZERO);

    // random values changed at random points, scoreboard only
    repeat (8) begin
      bus.value   = $urandom;
      bus.dp_mask = 8'($urandom_range(0, 255));
      step($urandom_range(1, 90));
    end
    step(FRAME + 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
